// File: rtl/slide_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : slide_sequencer
// Brief    : Turns timer ticks and next/prev buttons into an image index and
//            frame-buffer base address, committed only at vblank start.
// Revision : 1.0
// ============================================================================
module slide_sequencer #(
    parameter int NUM_IMAGES = 4,
    parameter int IMG_WORDS  = 65536,
    parameter int ADDR_W     = 20,
    parameter int IDX_W      = $clog2(NUM_IMAGES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              select,
    input  logic              tick_in,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              vblank_start,
    output logic [IDX_W-1:0]  img_index,
    output logic [ADDR_W-1:0] base_addr,
    output logic              swap_pending,
    output logic              frame_swap
);

    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NUM_IMAGES - 1);
    localparam logic [IDX_W-1:0] C_ONE  = IDX_W'(1);

    if ((NUM_IMAGES < 2) ||
        (longint'(NUM_IMAGES) * longint'(IMG_WORDS) > (longint'(1) << ADDR_W))) begin : g_check_size
        $error("slide_sequencer: NUM_IMAGES/IMG_WORDS do not fit ADDR_W");
    end

    logic              tick_prev_q, next_prev_q, prev_prev_q;
    logic [IDX_W-1:0]  target_q, target_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              pending_q, pending_d;
    logic              swap_q;

    logic              tick_edge, next_edge, prev_edge, fwd, commit;

    always_comb begin
        tick_edge = tick_in  & ~tick_prev_q;
        next_edge = btn_next & ~next_prev_q;
        prev_edge = btn_prev & ~prev_prev_q;
        fwd       = next_edge | (tick_edge & select);

        // Explicit compare-and-wrap keeps non-power-of-two image counts correct.
        target_d = target_q;
        if (fwd && !prev_edge) begin
            target_d = (target_q == C_LAST) ? '0 : target_q + C_ONE;
        end else if (!fwd && prev_edge) begin
            target_d = (target_q == '0) ? C_LAST : target_q - C_ONE;
        end

        // Commit takes the pre-step target; a same-cycle step stays pending.
        commit    = vblank_start && (target_q != index_q);
        index_d   = commit ? target_q : index_q;
        base_d    = commit ? ADDR_W'(target_q) * ADDR_W'(IMG_WORDS) : base_q;
        pending_d = (target_d != index_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_prev_q <= 1'b0;
            next_prev_q <= 1'b0;
            prev_prev_q <= 1'b0;
            target_q    <= '0;
            index_q     <= '0;
            base_q      <= '0;
            pending_q   <= 1'b0;
            swap_q      <= 1'b0;
        end else begin
            tick_prev_q <= tick_in;
            next_prev_q <= btn_next;
            prev_prev_q <= btn_prev;
            target_q    <= target_d;
            index_q     <= index_d;
            base_q      <= base_d;
            pending_q   <= pending_d;
            swap_q      <= commit;
        end
    end

    assign img_index    = index_q;
    assign base_addr    = base_q;
    assign swap_pending = pending_q;
    assign frame_swap   = swap_q;

endmodule
`default_nettype wire

// File: doc/slide_sequencer.md
# slide_sequencer

Downstream consumer of the 30-second timer's `finish_30sec` output. Converts timer ticks and user next/prev buttons into a current image index and frame-buffer base address for the VGA pixel fetch. Index changes are deferred to the next vertical-blank start, so the display never shows two images in one frame. The pixel fetch logic reads `base_addr` and offsets it by the pixel counter.

## Interface
Parameters:
- `NUM_IMAGES`, 4: number of stored images; index range 0..NUM_IMAGES-1; minimum 2.
- `IMG_WORDS`, 65536: words per image in the frame buffer.
- `ADDR_W`, 20: width of `base_addr`. Elaboration check: NUM_IMAGES*IMG_WORDS <= 2^ADDR_W.
- `IDX_W`, $clog2(NUM_IMAGES): width of the index.

Ports (one clock `clock`; reset `reset` is synchronous, active-high):
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous active-high reset.
- `select`  in  1  1 = auto mode (ticks advance); 0 = manual only.
- `tick_in`  in  1  `finish_30sec` level from the timer; its rising edge is the event.
- `btn_next`  in  1  synchronized, debounced level; its rising edge is the event.
- `btn_prev`  in  1  synchronized, debounced level; its rising edge is the event.
- `vblank_start`  in  1  one-cycle pulse from the VGA controller at the first vblank line.
- `img_index`  out  IDX_W  displayed image index.
- `base_addr`  out  ADDR_W  img_index*IMG_WORDS.
- `swap_pending`  out  1  a different target index is waiting for vblank.
- `frame_swap`  out  1  one-cycle pulse in the cycle `img_index` changes.

## Operation
- **Edge detection.** One previous-value register each for `tick_in`, `btn_next` and `btn_prev`.
  - edge = in & ~prev.
  - prev registers reset to 0, so an input that is high at reset release counts as an edge on the first cycle.
- **Step per cycle.** `fwd` = next_edge | (tick_edge & select). step = fwd − prev_edge, giving −1, 0 or +1.
  - fwd and prev_edge in the same cycle give step 0, and the events are discarded.
  - tick_edge while select=0 is ignored.
  - The buttons work in both modes.
- **Target register `target`.** Updated each cycle as target ← wrap(target + step), with modulo NUM_IMAGES wrap.
  - NUM_IMAGES−1 + 1 → 0.
  - 0 − 1 → NUM_IMAGES−1.
  - Must be correct for non-power-of-two NUM_IMAGES, so no bit truncation for wrap.
- **State (two states, derived):**
  - IDLE when target == img_index; PENDING otherwise. `swap_pending` = PENDING.
  - A next followed by a prev before vblank returns to IDLE with no swap.
- **Commit on `vblank_start` while PENDING:**
  - img_index ← target; base_addr ← target*IMG_WORDS.
  - frame_swap = 1 for one cycle.
- **`vblank_start` in IDLE:** no effect, and frame_swap stays 0.
- **`vblank_start` and a non-zero step in the same cycle:**
  - The commit uses the pre-step target.
  - target ← wrap(old target + step), which may leave PENDING set.
- **`base_addr` width.** Computed at full width, then assigned to ADDR_W bits; it is registered, not combinational.
- **Reset:**
  - img_index=0, base_addr=0, target=0, swap_pending=0, frame_swap=0, edge registers=0.
  - A reset mid-PENDING discards the request.

## Timing
- Input event sampled at edge N → target updated and swap_pending valid after edge N+1.
- vblank_start sampled at edge M while PENDING → img_index, base_addr and frame_swap valid after edge M+1.
- frame_swap deasserts after edge M+2 unless another commit occurs.
- Minimum event-to-display latency is 2 cycles: event at N, vblank_start at N+1.
- A held level produces one event only; a new event needs a low cycle first.
- Back-to-back edges on consecutive cycles are impossible per input. Different inputs on consecutive cycles each count.
- No combinational path from any input to any output.

## Test plan
- **Reset:** assert reset 2 cycles with all inputs low → img_index=0, base_addr=0, swap_pending=0, frame_swap=0.
- **Auto advance:** select=1, raise tick_in at N → swap_pending=1 at N+1. vblank_start at N+5 → img_index=1, base_addr=65536, frame_swap high exactly one cycle. tick held high 100 cycles → no second advance.
- **Manual wrap with select=0:**
  - btn_prev pulse then vblank → img_index=3, base_addr=196608.
  - btn_next then vblank → img_index=0.
  - tick_in edges are ignored throughout.
- **Cancel and simultaneity:**
  - next at N, prev at N+2 → swap_pending returns to 0, and the next vblank gives no frame_swap.
  - next and prev in the same cycle → no change.
  - tick and next in the same cycle with select=1 → single +1.
- **Commit plus event:** PENDING target=2 from index 1; vblank_start and btn_next in the same cycle → img_index=2, target=3, swap_pending=1, frame_swap=1.
- **Reset mid-operation and odd size:** NUM_IMAGES=3. Three nexts without vblank → target wraps to 0, swap_pending=0. One next, then reset before vblank → all outputs 0, and the following vblank gives no swap.
